// File: rtl/mem_bus_arbiter.sv
// Dual round-robin arbiter sharing the memory bus between ICache (0) and DCache (1),
// with one arbiter for the address/data channel and one for the store-data channel.
// Optional grant watchdog enabled by defining ARB_WATCHDOG_EN.
module mem_bus_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int OWNER_W     = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
    parameter int WDOG_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] addr_reqcyc,
    input  logic [NUM_REQ-1:0] addr_busy,
    output logic [NUM_REQ-1:0] addr_grant,
    output logic [OWNER_W-1:0] addr_owner,
    input  logic [NUM_REQ-1:0] store_reqcyc,
    input  logic [NUM_REQ-1:0] store_busy,
    output logic [NUM_REQ-1:0] store_grant,
    output logic [OWNER_W-1:0] store_owner,
    output logic [1:0]         wdog_timeout
);

    typedef enum logic [1:0] {
        StIdle,
        StGranted,
        StOwned
    } arb_state_e;

    if (WDOG_CYCLES < 1 || NUM_REQ < 1) begin : g_cfg_check
        $error("mem_bus_arbiter: NUM_REQ and WDOG_CYCLES must be at least 1");
    end

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned CntW = $clog2(WDOG_CYCLES + 1);
`endif

    // Channel 0 = address/data, channel 1 = store-data.
    logic [NUM_REQ-1:0] req_all   [2];
    logic [NUM_REQ-1:0] busy_all  [2];
    logic [NUM_REQ-1:0] grant_all [2];
    logic [OWNER_W-1:0] owner_all [2];
    logic               wdog_all  [2];

    assign req_all[0]  = addr_reqcyc;
    assign req_all[1]  = store_reqcyc;
    assign busy_all[0] = addr_busy;
    assign busy_all[1] = store_busy;

    assign addr_grant   = grant_all[0];
    assign addr_owner   = owner_all[0];
    assign store_grant  = grant_all[1];
    assign store_owner  = owner_all[1];
    assign wdog_timeout = {wdog_all[1], wdog_all[0]};

    for (genvar c = 0; c < 2; c++) begin : g_chan
        arb_state_e         state_q;
        logic [NUM_REQ-1:0] grant_q;
        logic [OWNER_W-1:0] owner_q;
        logic [OWNER_W-1:0] last_q;
        logic               found;
        logic [OWNER_W-1:0] winner;
        logic [OWNER_W-1:0] idx;
        logic [NUM_REQ-1:0] winner_oh;

        // Round-robin search starting one past the previous winner.
        always_comb begin
            found     = 1'b0;
            winner    = '0;
            idx       = '0;
            winner_oh = '0;
            for (int i = 1; i <= NUM_REQ; i++) begin
                idx = OWNER_W'((int'(last_q) + i) % NUM_REQ);
                if (!found && req_all[c][idx]) begin
                    found  = 1'b1;
                    winner = idx;
                end
            end
            winner_oh[winner] = found;
        end

`ifdef ARB_WATCHDOG_EN
        logic [CntW-1:0] wdog_cnt_q;
        logic            wdog_q;
        assign wdog_all[c] = wdog_q;
`else
        assign wdog_all[c] = 1'b0;
`endif

        assign grant_all[c] = grant_q;
        assign owner_all[c] = owner_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q    <= StIdle;
                grant_q    <= '0;
                owner_q    <= '0;
                last_q     <= OWNER_W'(NUM_REQ - 1);
`ifdef ARB_WATCHDOG_EN
                wdog_cnt_q <= '0;
                wdog_q     <= 1'b0;
`endif
            end else begin
`ifdef ARB_WATCHDOG_EN
                wdog_q <= 1'b0;
`endif
                unique case (state_q)
                    StIdle: begin
                        if (found) begin
                            state_q    <= StGranted;
                            grant_q    <= winner_oh;
                            owner_q    <= winner;
                            last_q     <= winner;
`ifdef ARB_WATCHDOG_EN
                            wdog_cnt_q <= '0;
`endif
                        end
                    end
                    StGranted: begin
                        if (busy_all[c][owner_q]) begin
                            state_q <= StOwned;
                        end else if (!req_all[c][owner_q]) begin
                            state_q <= StIdle;
                            grant_q <= '0;
                            owner_q <= '0;
`ifdef ARB_WATCHDOG_EN
                        end else if (wdog_cnt_q == CntW'(WDOG_CYCLES - 1)) begin
                            // Revoke; last_q keeps the revoked owner so the other side wins next.
                            state_q <= StIdle;
                            grant_q <= '0;
                            owner_q <= '0;
                            wdog_q  <= 1'b1;
                        end else begin
                            wdog_cnt_q <= wdog_cnt_q + CntW'(1);
`endif
                        end
                    end
                    StOwned: begin
                        if (!busy_all[c][owner_q]) begin
                            state_q <= StIdle;
                            grant_q <= '0;
                            owner_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        grant_q <= '0;
                        owner_q <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: each driven cycle pushes the expected post-edge outputs,
// a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;

    localparam int WDOG = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] addr_reqcyc = '0, addr_busy = '0, store_reqcyc = '0, store_busy = '0;
    logic [1:0] addr_grant, store_grant, wdog_timeout;
    logic       addr_owner, store_owner;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] ag;
        logic [1:0] sg;
        logic [1:0] wd;
    } exp_t;

    exp_t  sb_q [$];
    string tag_q [$];

    mem_bus_arbiter #(
        .NUM_REQ     (2),
        .OWNER_W     (1),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr_reqcyc  (addr_reqcyc),
        .addr_busy    (addr_busy),
        .addr_grant   (addr_grant),
        .addr_owner   (addr_owner),
        .store_reqcyc (store_reqcyc),
        .store_busy   (store_busy),
        .store_grant  (store_grant),
        .store_owner  (store_owner),
        .wdog_timeout (wdog_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare post-edge outputs against the oldest pending expectation.
    always @(negedge clk) begin
        exp_t  e;
        string t;
        if (!reset && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".ag"}, 32'(addr_grant), 32'(e.ag));
            check({t, ".ao"}, 32'(addr_owner), 32'(e.ag[1]));
            check({t, ".sg"}, 32'(store_grant), 32'(e.sg));
            check({t, ".so"}, 32'(store_owner), 32'(e.sg[1]));
            check({t, ".wd"}, 32'(wdog_timeout), 32'(e.wd));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input string tag, input logic [1:0] ar, input logic [1:0] ab,
                        input logic [1:0] sr, input logic [1:0] sbz,
                        input logic [1:0] eag, input logic [1:0] esg, input logic [1:0] ewd);
        exp_t e;
        @(negedge clk);
        #1;
        addr_reqcyc  = ar;
        addr_busy    = ab;
        store_reqcyc = sr;
        store_busy   = sbz;
        e.ag = eag;
        e.sg = esg;
        e.wd = ewd;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Assert reset between clock edges and confirm outputs clear without a clock edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check({tag, ".ag"}, 32'(addr_grant), 32'd0);
        check({tag, ".ao"}, 32'(addr_owner), 32'd0);
        check({tag, ".sg"}, 32'(store_grant), 32'd0);
        check({tag, ".wd"}, 32'(wdog_timeout), 32'd0);
        addr_reqcyc  = '0;
        addr_busy    = '0;
        store_reqcyc = '0;
        store_busy   = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1;
        check("rst.ag", 32'(addr_grant), 32'd0);
        check("rst.sg", 32'(store_grant), 32'd0);
        check("rst.wd", 32'(wdog_timeout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single requester on address/data channel.
        for (int i = 0; i < 3; i++) step("single", 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) step("single_busy", 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step("single_rel", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step("single_idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        async_reset("rst_idle");

        // Simultaneous requests alternate 0,1,0 with a dead cycle between owners.
        step("rr0", 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step("rr0_b", 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step("rr0_b", 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step("rr0_dead", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step("rr1", 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        step("rr1_b", 2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        step("rr1_b", 2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        step("rr1_dead", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step("rr2", 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step("rr2_b", 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step("rr2_rel", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Abandoned store request, then round-robin hands the next grant to requester 0.
        step("aband", 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00);
        step("aband_drop", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step("aband_next", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
        step("aband_rel", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Channel independence; reqcyc and non-owner busy ignored while owned.
        step("indep0", 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step("indep1", 2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00);
        step("indep2", 2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00);
        step("indep3", 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00);
        step("indep4", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Busy and reqcyc drop together while GRANTED: release.
        step("drop_both0", 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        step("drop_both1", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Reset during ownership.
        step("own0", 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step("own1", 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        async_reset("rst_owned");
        step("post_rst", 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);

`ifdef ARB_WATCHDOG_EN
        for (int i = 1; i < WDOG; i++) step("wdog_hold", 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step("wdog_revoke", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        step("wdog_next", 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
`else
        for (int i = 0; i < 110; i++) step("hold", 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
`endif
        step("end_rel", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
